// File: rtl/mfp_7seg_scan_ctrl_if.sv
// Register-side interface of the 7-segment scan controller: data load strobe plus status back to the register slave.
interface mfp_7seg_scan_ctrl_if #(parameter int N_DIGITS = 8);
   logic                  load;
   logic [4*N_DIGITS-1:0] digits;
   logic [N_DIGITS-1:0]   en;
   logic [N_DIGITS-1:0]   dp;
   logic                  frame_done;
   logic                  busy_pending;

   modport master (output load, digits, en, dp, input frame_done, busy_pending);
   modport slave  (input load, digits, en, dp, output frame_done, busy_pending);
endinterface

// File: rtl/mfp_7seg_scan_ctrl.sv
// Time-multiplexed scan of an N-digit common-anode 7-segment display with
// double-buffered digit data applied only at frame boundaries.
module mfp_7seg_scan_ctrl #(
   parameter int N_DIGITS     = 8,
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   mfp_7seg_scan_ctrl_if.slave   bus,
   output logic [N_DIGITS-1:0]   AN,
   output logic [6:0]            SEG_N,
   output logic                  DP_N
);

   localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t                state;
   logic [IW-1:0]         idx;
   logic [CW-1:0]         cnt;

   logic [4*N_DIGITS-1:0] digits_act, digits_pend;
   logic [N_DIGITS-1:0]   en_act, en_pend;
   logic [N_DIGITS-1:0]   dp_act, dp_pend;
   logic                  busy_q;
   logic                  frame_done_q;

   logic [N_DIGITS-1:0]   show_an;
   logic [6:0]            show_seg;
   logic                  show_dp;

   function automatic logic [6:0] font(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'h01;  4'h1: s = 7'h4F;  4'h2: s = 7'h12;  4'h3: s = 7'h06;
         4'h4: s = 7'h4C;  4'h5: s = 7'h24;  4'h6: s = 7'h20;  4'h7: s = 7'h0F;
         4'h8: s = 7'h00;  4'h9: s = 7'h04;  4'hA: s = 7'h08;  4'hB: s = 7'h60;
         4'hC: s = 7'h31;  4'hD: s = 7'h42;  4'hE: s = 7'h30;  default: s = 7'h38;
      endcase
      return s;
   endfunction

   // Pin values for the SHOW phase of the current digit; registered on SHOW entry.
   always_comb begin
      show_an      = '1;
      show_an[idx] = ~en_act[idx];
      show_seg     = font(digits_act[4*int'(idx) +: 4]);
      show_dp      = ~dp_act[idx];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= ST_BLANK;
         idx          <= '0;
         cnt          <= '0;
         digits_act   <= '0;
         en_act       <= '0;
         dp_act       <= '0;
         digits_pend  <= '0;
         en_pend      <= '0;
         dp_pend      <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         AN           <= '1;
         SEG_N        <= 7'h7F;
         DP_N         <= 1'b1;
      end else begin
         frame_done_q <= 1'b0;
         if (bus.load) begin
            digits_pend <= bus.digits;
            en_pend     <= bus.en;
            dp_pend     <= bus.dp;
            busy_q      <= 1'b1;
         end
         unique case (state)
            ST_BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state <= ST_SHOW;
                  cnt   <= '0;
                  AN    <= show_an;
                  SEG_N <= show_seg;
                  DP_N  <= show_dp;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               if (cnt == SHOW_LAST) begin
                  state <= ST_BLANK;
                  cnt   <= '0;
                  idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                  AN    <= '1;
                  SEG_N <= 7'h7F;
                  DP_N  <= 1'b1;
                  // Frame boundary: a load on this very edge bypasses the pending
                  // buffer; these assignments override the pending capture above.
                  if (idx == IDX_LAST) begin
                     frame_done_q <= 1'b1;
                     if (bus.load) begin
                        digits_act <= bus.digits;
                        en_act     <= bus.en;
                        dp_act     <= bus.dp;
                        busy_q     <= 1'b0;
                     end else if (busy_q) begin
                        digits_act <= digits_pend;
                        en_act     <= en_pend;
                        dp_act     <= dp_pend;
                        busy_q     <= 1'b0;
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.frame_done   = frame_done_q;
   assign bus.busy_pending = busy_q;

endmodule

// File: tb/tb_mfp_7seg_scan_ctrl.sv
// Bench for mfp_7seg_scan_ctrl: directed scenarios plus random loads, checked
// every cycle against a model that derives phase and digit from the cycle count.
module tb_mfp_7seg_scan_ctrl;
   localparam int ND    = 8;
   localparam int PS    = 4;
   localparam int BC    = 2;
   localparam int SLOT  = PS + BC;
   localparam int FRAME = ND * SLOT;

   logic          clk = 1'b0;
   logic          resetn;
   logic [ND-1:0] AN;
   logic [6:0]    SEG_N;
   logic          DP_N;

   mfp_7seg_scan_ctrl_if #(.N_DIGITS(ND)) bus ();

   mfp_7seg_scan_ctrl #(.N_DIGITS(ND), .PRESCALE(PS), .BLANK_CYCLES(BC)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave),
      .AN     (AN),
      .SEG_N  (SEG_N),
      .DP_N   (DP_N)
   );

   always #5 clk = ~clk;

   logic [6:0] FONT [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   int n_checks = 0;
   int n_errors = 0;

   // Model state: k = rising edges since reset release.
   int          k;
   logic [31:0] m_dig, m_pdig;
   logic [7:0]  m_en, m_pen, m_dp, m_pdp;
   bit          m_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s k=%0d got %h want %h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      k = 0;
      m_dig = '0; m_pdig = '0; m_en = '0; m_pen = '0; m_dp = '0; m_pdp = '0;
      m_busy = 1'b0;
   endtask

   task automatic model_edge(input bit ld, input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
      k++;
      if (k % FRAME == 0) begin
         if (ld) begin
            m_dig = d; m_en = e; m_dp = p; m_busy = 1'b0;
         end else if (m_busy) begin
            m_dig = m_pdig; m_en = m_pen; m_dp = m_pdp; m_busy = 1'b0;
         end
      end else if (ld) begin
         m_pdig = d; m_pen = e; m_pdp = p; m_busy = 1'b1;
      end
   endtask

   task automatic check_outputs();
      int         m, slot;
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic [3:0] nib;
      m     = k % FRAME;
      slot  = m / SLOT;
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if ((m % SLOT) >= BC) begin
         nib        = m_dig[slot*4 +: 4];
         e_an[slot] = ~m_en[slot];
         e_seg      = FONT[nib];
         e_dp       = ~m_dp[slot];
      end
      check("AN", 32'(AN), 32'(e_an));
      check("SEG_N", 32'(SEG_N), 32'(e_seg));
      check("DP_N", 32'(DP_N), 32'(e_dp));
      check("frame_done", 32'(bus.frame_done), 32'((k > 0) && (m == 0)));
      check("busy_pending", 32'(bus.busy_pending), 32'(m_busy));
   endtask

   task automatic tick(input bit ld, input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
      bus.load = ld; bus.digits = d; bus.en = e; bus.dp = p;
      @(posedge clk);
      model_edge(ld, d, e, p);
      #1;
      bus.load = 1'b0;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, '0, '0, '0);
   endtask

   task automatic run_to(input int pos);
      for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) tick(1'b0, '0, '0, '0);
   endtask

   initial begin
      resetn = 1'b0;
      bus.load = 1'b0; bus.digits = '0; bus.en = '0; bus.dp = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      resetn = 1'b1;
      check_outputs();

      idle(100);

      tick(1'b1, 32'h76543210, 8'hFF, 8'h01);
      idle(110);

      tick(1'b1, 32'hFEDCBA98, 8'hF0, 8'hFF);
      idle(110);

      run_to(10);
      tick(1'b1, 32'h11111111, 8'hFF, 8'h00);
      idle(2);
      tick(1'b1, 32'h22222222, 8'hFF, 8'h00);
      idle(100);

      run_to(FRAME - 1);
      tick(1'b1, 32'h89ABCDEF, 8'hAA, 8'h55);
      idle(60);

      run_to(5);
      tick(1'b1, 32'hC0FFEE55, 8'hFF, 8'hFF);
      run_to(3 * SLOT + BC);
      #2;
      resetn = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      resetn = 1'b1;
      check_outputs();
      idle(100);

      for (int i = 0; i < 800; i++)
         tick($urandom_range(0, 9) == 0, $urandom, 8'($urandom), 8'($urandom));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
